// File: rtl/cordic_pkg.sv
// Shared Q-format constants and opcode encodings for the CORDIC datapath.
// Pure definitions, no logic, so there is no latency.
// Carries no handshake, so there is no backpressure.
package cordic_pkg;

    localparam int CORDIC_N    = 32;
    localparam int CORDIC_FRAC = 29;

    localparam logic [CORDIC_N-1:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [CORDIC_N-1:0] QMIN = 32'h8000_0000;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_sat.sv
// Combinational signed add/subtract with overflow detection and optional saturation.
// Latency: none, purely combinational.
// Backpressure: none, no handshake.
module add_sub_sat
    import cordic_pkg::*;
#(
    parameter int N   = CORDIC_N,
    parameter bit SAT = 1'b1
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         a_s,
    output logic [N-1:0] res,
    output logic         ovf
);

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    logic [N:0] xe;
    logic [N:0] ye;
    logic [N:0] sum;

    // One guard bit keeps X - (most negative) representable, so the sign pair flags it.
    assign xe  = {x[N-1], x};
    assign ye  = {y[N-1], y};
    assign sum = (a_s == OP_SUB) ? (xe - ye) : (xe + ye);
    assign ovf = sum[N] ^ sum[N-1];

    always_comb begin
        res = sum[N-1:0];
        if (SAT && ovf) begin
            res = sum[N] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined saturating add/sub with valid/ready handshake and sticky overflow flag.
// Latency: STAGES cycles from input transfer to out_valid; one result per cycle sustained.
// Backpressure: bubble-collapsing stages; in_ready drops only when every stage is full and stalled.
module add_sub_pipe
    import cordic_pkg::*;
#(
    parameter int N      = CORDIC_N,
    parameter int FRAC   = CORDIC_FRAC,
    parameter int STAGES = 2,
    parameter bit SAT    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         a_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         ovf,
    output logic         ovf_sticky,
    input  logic         clr_ovf
);

    if (STAGES < 1 || FRAC >= N) begin : g_bad_param
        $error("add_sub_pipe: STAGES must be >= 1 and FRAC must be below N");
    end

    typedef struct packed {
        logic         vld;
        logic         ovf;
        logic [N-1:0] dat;
    } stage_t;

    stage_t              stg [STAGES];
    logic [STAGES-1:0]   adv;
    logic [STAGES-1:0]   acc;
    logic [N-1:0]        alu_res;
    logic                alu_ovf;
    logic                in_fire;

    add_sub_sat #(.N(N), .SAT(SAT)) u_alu (
        .x   (X),
        .y   (Y),
        .a_s (a_s),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    // Ready ripples back from out_ready: a stage accepts if empty or draining this cycle.
    always_comb begin
        adv = '0;
        acc = '0;
        adv[STAGES-1] = stg[STAGES-1].vld & out_ready;
        acc[STAGES-1] = ~stg[STAGES-1].vld | adv[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = stg[k].vld & acc[k+1];
            acc[k] = ~stg[k].vld | adv[k];
        end
    end

    assign in_ready = acc[0];
    assign in_fire  = in_valid & acc[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k] <= '0;
            end
            ovf_sticky <= 1'b0;
        end else begin
            if (acc[0]) begin
                stg[0].vld <= in_valid;
                if (in_valid) begin
                    stg[0].dat <= alu_res;
                    stg[0].ovf <= alu_ovf;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (acc[k]) begin
                    stg[k].vld <= stg[k-1].vld;
                    if (stg[k-1].vld) begin
                        stg[k].dat <= stg[k-1].dat;
                        stg[k].ovf <= stg[k-1].ovf;
                    end
                end
            end
            // A new overflow outranks a clear arriving on the same edge.
            if (in_fire && alu_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign out_valid = stg[STAGES-1].vld;
    assign result    = stg[STAGES-1].dat;
    assign ovf       = stg[STAGES-1].ovf;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: u0 uses default parameters, u1 uses STAGES=3 with wrap-around.
// Directed steps drive both instances; a scoreboard checks every result that leaves either one.
module tb_add_sub_pipe;
    import cordic_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid, a_s, out_ready, clr_ovf;
    logic [31:0] xv [2];
    logic [31:0] yv [2];
    wire  [1:0]  in_ready, out_valid, ovf, ovf_sticky;
    wire  [31:0] res [2];

    exp_t q0 [$];
    exp_t q1 [$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [1:0]  hold_vld = 2'b00;
    exp_t        hold_val [2];

    always #5 clk = ~clk;

    add_sub_pipe u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .X(xv[0]), .Y(yv[0]), .a_s(a_s[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(res[0]), .ovf(ovf[0]),
        .ovf_sticky(ovf_sticky[0]), .clr_ovf(clr_ovf[0])
    );

    add_sub_pipe #(.N(32), .FRAC(29), .STAGES(3), .SAT(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .X(xv[1]), .Y(yv[1]), .a_s(a_s[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(res[1]), .ovf(ovf[1]),
        .ovf_sticky(ovf_sticky[1]), .clr_ovf(clr_ovf[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference arithmetic in 64-bit integers, independent of the bit-level formulation.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input bit sat);
        longint a, b, r;
        exp_t   e;
        a = longint'(signed'(x));
        b = longint'(signed'(y));
        r = s ? (a - b) : (a + b);
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.r = r[31:0];
        if (e.o && sat) e.r = (r > 0) ? QMAX : QMIN;
        return e;
    endfunction

    // Present one operation on instance s, wait for acceptance, then record its expectation.
    task automatic op(input int s, input logic [31:0] x, input logic [31:0] y,
                      input logic as_, input logic [31:0] er, input logic eo);
        bit   done = 1'b0;
        exp_t e;
        xv[s] = x; yv[s] = y; a_s[s] = as_; in_valid[s] = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = in_ready[s];
            @(posedge clk);
            #1;
        end
        in_valid[s] = 1'b0;
        e.r = er; e.o = eo;
        if (!done) chk("op_accept_timeout", 0, 1);
        else if (s == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drain(input int s);
        int c = 0;
        while (((s == 0) ? q0.size() : q1.size()) != 0 && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", (s == 0) ? q0.size() : q1.size(), 0);
    endtask

    // Output side: pop on each output transfer, and check holding while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q0.delete();
            q1.delete();
            hold_vld = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hold_vld[i] && out_valid[i]) begin
                    chk("stall_hold", {res[i], ovf[i]}, hold_val[i]);
                end
                if (out_valid[i] && out_ready[i]) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk("sb_result", res[i], e.r);
                        chk("sb_ovf", ovf[i], e.o);
                    end
                end
                hold_vld[i] = out_valid[i] & ~out_ready[i];
                hold_val[i] = {res[i], ovf[i]};
            end
        end
    end

    initial begin
        int   acc;
        logic rdy;
        logic [31:0] bx, by;
        logic bs;
        exp_t e;

        rst = 1'b1; in_valid = '0; a_s = '0; out_ready = '0; clr_ovf = '0;
        xv[0] = '0; yv[0] = '0; xv[1] = '0; yv[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_result", res[0], 32'h0);
        chk("rst_ovf", ovf, 2'b00);
        chk("rst_sticky", ovf_sticky, 2'b00);
        chk("rst_in_ready", in_ready, 2'b11);
        rst = 1'b0;
        out_ready = 2'b11;

        // Latency and basic add/sub on default parameters.
        op(0, 32'hF5F3B646, 32'h1D1EB851, OP_ADD, 32'h13126E97, 1'b0);
        chk("lat_add_not_yet", out_valid[0], 1'b0);
        @(posedge clk); #1;
        chk("lat_add_valid", out_valid[0], 1'b1);
        chk("lat_add_result", res[0], 32'h13126E97);
        op(0, 32'hF5F3B646, 32'h1D1EB851, OP_SUB, 32'hD8D4FDF5, 1'b0);
        chk("lat_sub_not_yet", out_valid[0], 1'b0);
        @(posedge clk); #1;
        chk("lat_sub_valid", out_valid[0], 1'b1);
        chk("lat_sub_result", res[0], 32'hD8D4FDF5);
        drain(0);
        chk("sticky_before_sat", ovf_sticky[0], 1'b0);

        // Saturation corners.
        op(0, 32'h70000000, 32'h20000000, OP_ADD, 32'h7FFFFFFF, 1'b1);
        chk("sticky_after_sat", ovf_sticky[0], 1'b1);
        op(0, 32'h00000000, 32'h80000000, OP_SUB, 32'h7FFFFFFF, 1'b1);
        op(0, 32'h80000000, 32'h00000001, OP_SUB, 32'h80000000, 1'b1);
        drain(0);

        // Sticky clear, then set-beats-clear on the same edge.
        clr_ovf[0] = 1'b1;
        @(posedge clk); #1;
        clr_ovf[0] = 1'b0;
        chk("sticky_cleared", ovf_sticky[0], 1'b0);
        clr_ovf[0] = 1'b1;
        op(0, 32'h70000000, 32'h20000000, OP_ADD, 32'h7FFFFFFF, 1'b1);
        clr_ovf[0] = 1'b0;
        chk("sticky_set_wins", ovf_sticky[0], 1'b1);
        clr_ovf[0] = 1'b1;
        @(posedge clk); #1;
        clr_ovf[0] = 1'b0;
        chk("sticky_cleared_again", ovf_sticky[0], 1'b0);
        drain(0);

        // Wrap-around on the SAT=0 instance.
        op(1, 32'h70000000, 32'h20000000, OP_ADD, 32'h90000000, 1'b1);
        drain(1);

        // Backpressure on STAGES=3: output stalled for five cycles.
        out_ready[1] = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            bx = 32'h01000000 * (acc + 1) + acc;
            by = 32'h00030000 + 7 * acc;
            bs = acc[0];
            xv[1] = bx; yv[1] = by; a_s[1] = bs; in_valid[1] = 1'b1;
            @(negedge clk);
            rdy = in_ready[1];
            if (acc >= 3) chk("bp_full_in_ready", rdy, 1'b0);
            else chk("bp_filling_in_ready", rdy, 1'b1);
            @(posedge clk); #1;
            if (rdy) begin
                q1.push_back(model(bx, by, bs, 1'b0));
                acc++;
            end
        end
        chk("bp_accepted", acc, 3);
        out_ready[1] = 1'b1;
        for (int c = 0; c < 20 && acc < 6; c++) begin
            bx = 32'h01000000 * (acc + 1) + acc;
            by = 32'h00030000 + 7 * acc;
            bs = acc[0];
            xv[1] = bx; yv[1] = by; a_s[1] = bs; in_valid[1] = 1'b1;
            @(negedge clk);
            rdy = in_ready[1];
            chk("tput_in_ready", rdy, 1'b1);
            @(posedge clk); #1;
            if (rdy) begin
                q1.push_back(model(bx, by, bs, 1'b0));
                acc++;
            end
        end
        in_valid[1] = 1'b0;
        chk("bp_accepted_all", acc, 6);
        drain(1);

        // Reset with two operations held in flight.
        out_ready[0] = 1'b0;
        e = model(32'h70000000, 32'h20000000, OP_ADD, 1'b1);
        op(0, 32'h70000000, 32'h20000000, OP_ADD, e.r, e.o);
        op(0, 32'hF5F3B646, 32'h1D1EB851, OP_ADD, 32'h13126E97, 1'b0);
        chk("inflight_valid", out_valid[0], 1'b1);
        chk("inflight_in_ready", in_ready[0], 1'b0);
        chk("inflight_sticky", ovf_sticky[0], 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid[0], 1'b0);
        chk("midrst_sticky", ovf_sticky[0], 1'b0);
        chk("midrst_in_ready", in_ready[0], 1'b1);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", out_valid[0], 1'b0);
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Pipelined, parametrised fixed-point adder/subtractor for the CORDIC datapath.
- Default format is Q3.29; width and fraction bits are parametrised.
- Adds a valid/ready handshake, configurable pipeline depth, saturation on overflow, and a sticky overflow status.
- Sits between the angle/coordinate registers and the CORDIC iteration logic, and serves as the shared arithmetic primitive for X/Y/Z updates.

Parameters:
- N, 32, total data width (two's complement).
- FRAC, 29, fractional bits. Informational only; no effect on arithmetic, passed through for assertions and bench scaling.
- STAGES, 2, number of register stages (>=1). Stage 0 holds the computed result; stages 1..STAGES-1 are delay/buffer stages.
- SAT, 1, 1 = saturate on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- X  in  N  signed operand A.
- Y  in  N  signed operand B.
- a_s  in  1  0 = X+Y, 1 = X-Y.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  N  signed result.
- ovf  out  1  overflow occurred for this result (travels with result).
- ovf_sticky  out  1  set by any accepted overflowing operation; held until cleared.
- clr_ovf  in  1  clears ovf_sticky.

Behaviour:
- Reset: one clock, synchronous, active-high. On the first rising edge with rst=1, clear all stage valid bits. Outputs after that edge: out_valid=0, result=0, ovf=0, ovf_sticky=0. in_ready=1 in the cycle following reset.
- Reset mid-operation: in-flight data is discarded; no out_valid is produced for it.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Arithmetic (stage 0):
  - Sign-extend X and Y to N+1 bits.
  - Compute s = Xe + (a_s ? -Ye : Ye) in N+1 bits.
  - Overflow = s[N] != s[N-1]. This correctly flags X - (-2^(N-1)).
- Result selection:
  - SAT=1 and overflow: result = 2^(N-1)-1 if s[N]=0, else -2^(N-1).
  - Otherwise: result = s[N-1:0].
- Pipeline:
  - Each stage k holds {valid, data, ovf}.
  - Stage k loads from stage k-1 when it is empty or its own contents move on in the same cycle (bubble-collapsing).
  - Last stage drains on an output transfer.
  - in_ready = !valid[0] || stage 0 advances this cycle. in_ready is combinational from out_ready through the valid chain; no other combinational input-to-output paths.
- Latency: with no backpressure, exactly STAGES cycles from input transfer to out_valid. Full throughput is one result per cycle.
- Capacity: STAGES entries. With out_ready held low, STAGES operand sets are accepted, after which in_ready=0. Results are never dropped, duplicated or reordered.
- While out_valid=1 and out_ready=0, result and ovf are held stable.
- ovf_sticky:
  - Set on the cycle stage 0 loads an overflowing operation.
  - clr_ovf clears it on the next edge.
  - Simultaneous set and clear: set wins, so ovf_sticky=1.
- Simultaneous input and output transfer with the pipeline full: both occur; occupancy is unchanged.

Decomposition:
- cordic_pkg holds:
  - Q-format constants: CORDIC_N=32, CORDIC_FRAC=29.
  - Saturation limits: QMAX=32'h7FFFFFFF, QMIN=32'h80000000.
  - Named a_s encodings: OP_ADD=0, OP_SUB=1.
- One combinational sub-module, add_sub_sat (N, SAT), computes the N+1-bit sum, overflow and saturated result.
- add_sub_pipe instantiates add_sub_sat and implements the stage registers and handshake.

Test Plan:
- Add/sub, default params, out_ready=1: X=32'hF5F3B646 (-0.314), Y=32'h1D1EB851 (0.91).
  - a_s=0 -> result=32'h13126E97, ovf=0.
  - a_s=1 -> result=32'hD8D4FDF5, ovf=0.
  - Each result appears exactly 2 cycles after its input transfer.
- Saturation, SAT=1:
  - X=32'h70000000, Y=32'h20000000, a_s=0 -> 32'h7FFFFFFF, ovf=1.
  - X=0, Y=32'h80000000, a_s=1 -> 32'h7FFFFFFF, ovf=1.
  - X=32'h80000000, Y=32'h00000001, a_s=1 -> 32'h80000000, ovf=1.
  - ovf_sticky=1 after the first of these.
- Wrap, SAT=0: X=32'h70000000, Y=32'h20000000, a_s=0 -> 32'h90000000, ovf=1.
- Backpressure, STAGES=3: stream 6 distinct ops with out_ready=0 for 5 cycles.
  - in_ready falls after 3 accepts.
  - All 6 results emerge in order with no loss or duplicates.
  - result is stable while stalled.
  - With in_valid and out_ready held at 1 afterwards, one transfer occurs per cycle.
- Reset mid-stream: assert rst with 2 ops in flight.
  - Next edge: out_valid=0, ovf_sticky=0.
  - No stale result appears afterwards.
  - in_ready=1.
- Sticky clear: clr_ovf asserted in the same cycle an overflowing op loads stage 0 -> ovf_sticky stays 1. A later clr_ovf with no overflow -> ovf_sticky=0.
